// File: rtl/alu_pkg.sv
// alu_pkg: shared instruction field positions, opcode encodings and widths for the ALU issue stage
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int RIDX_W = 3;

    // Instruction field positions
    localparam int FC_HI = 23;
    localparam int FC_LO = 22;
    localparam int LF_HI = 21;
    localparam int LF_LO = 20;
    localparam int C0_BIT = 19;
    localparam int SD_BIT = 18;
    localparam int CV_BIT = 17;
    localparam int CA_HI = 16;
    localparam int CA_LO = 12;
    localparam int RD_HI = 11;
    localparam int RD_LO = 9;
    localparam int RA_HI = 8;
    localparam int RA_LO = 6;
    localparam int RB_HI = 5;
    localparam int RB_LO = 3;

    typedef enum logic [1:0] {
        FC_SHIFT  = 2'd0,
        FC_SLT    = 2'd1,
        FC_ADDSUB = 2'd2,
        FC_LOGIC  = 2'd3
    } fclass_t;

    typedef enum logic [1:0] {
        LF_AND = 2'd0,
        LF_OR  = 2'd1,
        LF_XOR = 2'd2,
        LF_NOR = 2'd3
    } lfunc_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: register file with one write port and two combinational read ports, asynchronous clear
module alu_regfile #(
    parameter int NREGS  = 8,
    parameter int RIDX_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RIDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RIDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NREGS];

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

    // Single write port; the parent has already chosen between writeback and load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issues one instruction per cycle to an external ALU and writes its result back
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter int RIDX_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [23:0]       instr,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [RIDX_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_c_0,
    output logic              alu_const_var,
    output logic              alu_shift_direction,
    output logic [1:0]        alu_function_class,
    output logic [1:0]        alu_logic_function,
    output logic [4:0]        alu_const_amount,
    input  logic [DATA_W-1:0] alu_s,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result_data,
    output logic [RIDX_W-1:0] result_rd
);

    logic              issue_valid;
    logic              advance;
    logic              accept;
    logic              ld_acc;
    logic              unused_reserved;
    logic [RIDX_W-1:0] rd_q;
    logic [RIDX_W-1:0] ra;
    logic [RIDX_W-1:0] rb;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    assign advance     = issue_valid && (!result_valid || result_ready);
    assign instr_ready = !issue_valid || advance;
    assign ld_ready    = !advance;
    assign accept      = instr_valid && instr_ready;
    assign ld_acc      = ld_valid && ld_ready;
    assign ra          = instr[RA_HI:RA_LO];
    assign rb          = instr[RB_HI:RB_LO];
    assign unused_reserved = ^instr[2:0];

    // Operand forwarding: in-flight ALU result first, then a same-edge load, then the register file
    always_comb begin
        fwd_a = (advance && rd_q == ra) ? alu_s : (ld_acc && ld_addr == ra) ? ld_data : rdata_a;
        fwd_b = (advance && rd_q == rb) ? alu_s : (ld_acc && ld_addr == rb) ? ld_data : rdata_b;
    end

    alu_regfile #(
        .NREGS (NREGS),
        .RIDX_W(RIDX_W),
        .DATA_W(DATA_W)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (advance || ld_acc),
        .waddr  (advance ? rd_q : ld_addr),
        .wdata  (advance ? alu_s : ld_data),
        .raddr_a(ra),
        .rdata_a(rdata_a),
        .raddr_b(rb),
        .rdata_b(rdata_b)
    );

    // Issue register: latches operands and control on accept, holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid         <= 1'b0;
            rd_q                <= '0;
            alu_a               <= '0;
            alu_b               <= '0;
            alu_c_0             <= 1'b0;
            alu_const_var       <= 1'b0;
            alu_shift_direction <= 1'b0;
            alu_function_class  <= '0;
            alu_logic_function  <= '0;
            alu_const_amount    <= '0;
        end else begin
            issue_valid <= accept || (issue_valid && !advance);
            if (accept) begin
                rd_q                <= instr[RD_HI:RD_LO];
                alu_a               <= fwd_a;
                alu_b               <= fwd_b;
                alu_c_0             <= instr[C0_BIT];
                alu_const_var       <= instr[CV_BIT];
                alu_shift_direction <= instr[SD_BIT];
                alu_function_class  <= instr[FC_HI:FC_LO];
                alu_logic_function  <= instr[LF_HI:LF_LO];
                alu_const_amount    <= instr[CA_HI:CA_LO];
            end
        end
    end

    // Result slot: filled on advance, drained when the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid <= 1'b0;
            result_data  <= '0;
            result_rd    <= '0;
        end else if (advance) begin
            result_valid <= 1'b1;
            result_data  <= alu_s;
            result_rd    <= rd_q;
        end else if (result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Upstream issue and writeback stage for the 32-bit combinational ALU. It accepts one instruction per cycle through a valid/ready handshake and reads two operands from an internal 8x32 register file. It drives every ALU control and operand input from registered state, then captures the ALU result into the register file and a result output slot with backpressure. It also provides a load port so software or a testbench can preload registers.

Parameters:
NREGS, 8, number of register-file entries; fixed power of two.
RIDX_W, 3, register index width; equals log2(NREGS).
DATA_W, 32, datapath width; must match the ALU width.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous active-high reset.
instr_valid  in  1  instruction offered.
instr_ready  out  1  instruction accepted when valid and ready are both high.
instr  in  24  [23:22] function_class, [21:20] logic_function, [19] c_0, [18] shift_direction, [17] const_var, [16:12] const_amount, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] reserved (ignored).
ld_valid  in  1  register preload request.
ld_ready  out  1  preload accepted when valid and ready are both high.
ld_addr  in  3  preload destination.
ld_data  in  32  preload value.
alu_a  out  32  ALU operand a.
alu_b  out  32  ALU operand b.
alu_c_0  out  1  ALU carry-in / subtract select.
alu_const_var  out  1  ALU shift-amount source select.
alu_shift_direction  out  1  ALU shift direction.
alu_function_class  out  2  ALU function class.
alu_logic_function  out  2  ALU logic function.
alu_const_amount  out  5  ALU constant shift amount.
alu_s  in  32  combinational ALU result.
result_valid  out  1  result slot full.
result_ready  in  1  consumer takes the result.
result_data  out  32  captured ALU result.
result_rd  out  3  destination index of the captured result.

Behaviour:
- Reset (async, rst=1): issue_valid=0, result_valid=0, result_data=0, result_rd=0, all alu_* outputs=0, all register-file entries=0. Reset asserted mid-instruction discards the in-flight instruction and the pending result. No write occurs on the reset edge.
- Two state bits: issue_valid (instruction held at the ALU) and result_valid (result slot full).
- advance = issue_valid && (!result_valid || result_ready).
- instr_ready = !issue_valid || advance. This path is combinational from result_ready.
- Accept edge (instr_valid && instr_ready):
  - Latch the control fields into the alu_* registers.
  - Read rf[ra] into alu_a and rf[rb] into alu_b, with forwarding applied.
  - Set issue_valid=1.
- Hold: while issue_valid && !advance, every alu_* output holds and no register-file write occurs.
- Advance edge:
  - Write rf[rd] <= alu_s.
  - Set result_data <= alu_s, result_rd <= rd, result_valid <= 1.
  - issue_valid <= 1 if an instruction is accepted on the same edge, otherwise 0.
- Result slot drains (result_valid <= 0) on the edge where result_valid && result_ready && !advance.
- Latency: instruction accepted at edge N -> result_valid and register-file write at edge N+1 when unstalled. Throughput is one instruction per cycle.
- Forwarding priority for each operand on an accept edge:
  1. alu_s, if advance and rd equals the operand index.
  2. ld_data, if a load is accepted on the same edge to the same index.
  3. Register file.
  - ra==rb is legal; both operands receive the same value.
- Load port:
  - ld_ready = !advance. ALU writeback has priority.
  - On an accepted load, rf[ld_addr] <= ld_data.
  - A load and an advance never write on the same edge.
- result_data and the alu_* outputs are driven only from registers; no combinational path from instr to them.
- Reserved bits [2:0] are ignored. The sticky function_class=01 result (SLT bit) is written back like any other result.

Decomposition:
- Shared package alu_pkg holds:
  - instruction field-position constants;
  - function_class codes: SHIFT=0, SLT=1, ADDSUB=2, LOGIC=3;
  - logic codes: AND=0, OR=1, XOR=2, NOR=3;
  - DATA_W and RIDX_W.
- One sub-module, alu_regfile: 8x32, one write port with priority already resolved by the parent, two combinational read ports, asynchronous clear.
- Forwarding muxes and the handshake stay in alu_issue_stage.

Test Plan:
1. Preload r1=10 and r2=5, then issue ADDSUB c_0=1 rd=3 ra=1 rb=2. Required: result_valid one cycle after accept, result_data=5, result_rd=3, rf[3]=5.
2. Back-to-back dependency: issue ADDSUB c_0=0 r3=r1+r2, then LOGIC XOR r4=r3^r1 on the next cycle. Required: second alu_a=15 via forwarding, result 15^10=5.
3. Backpressure: result_ready=0 with two instructions offered. Required:
   - first result holds;
   - instr_ready drops after the second is accepted;
   - alu_* outputs stay stable;
   - releasing result_ready yields both results in order on consecutive cycles.
4. Load/writeback conflict: ld_valid is high on an advance cycle. Required: ld_ready=0 that cycle; the load completes on the next cycle; rf holds the load value.
5. SHIFT with const_var selecting const_amount=7, b=321, shift_direction=0 (right shift). Required: result 2.
6. Assert rst mid-stall with result_valid=1. Required: all outputs 0 immediately (asynchronous); registers read 0 afterwards; no spurious write.
